// File: rtl/matrix_job_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matrix_job_arbiter_if : requester, accelerator and response signal bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface matrix_job_arbiter_if #(
  parameter int BIT_LEN = 16,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*BIT_LEN-1:0] req_data;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         req_pop;
  logic [BIT_LEN-1:0]         acc_data;
  logic                       acc_wr;
  logic                       acc_full;
  logic                       acc_start;
  logic                       acc_ready;
  logic [2*BIT_LEN-1:0]       acc_sum;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [ID_W-1:0]            resp_id;
  logic [2*BIT_LEN-1:0]       resp_sum;
  logic                       resp_err;
  logic                       busy;

  // master = the arbiter; slave = requesters, accelerator and response sink
  modport master (
    input  req, req_data, acc_full, acc_ready, acc_sum, resp_ready,
    output grant, req_pop, acc_data, acc_wr, acc_start,
           resp_valid, resp_id, resp_sum, resp_err, busy
  );

  modport slave (
    output req, req_data, acc_full, acc_ready, acc_sum, resp_ready,
    input  grant, req_pop, acc_data, acc_wr, acc_start,
           resp_valid, resp_id, resp_sum, resp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/matrix_job_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matrix_job_arbiter : round-robin sharing of one matrix accelerator
// Rev 1.0
// ----------------------------------------------------------------------------
module matrix_job_arbiter #(
  parameter int BIT_LEN = 16,
  parameter int NUM_REQ = 2,
  parameter int JOB_LEN = 18,
  parameter int TIMEOUT = 1023,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  matrix_job_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(JOB_LEN + 1);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]      gidx_q, gidx_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [2*BIT_LEN-1:0] sum_q, sum_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   req_rot;
  logic                 found;
  logic [ID_W-1:0]      pick;
  logic                 xfer;
  logic [BIT_LEN-1:0]   words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = bus.req_data[i*BIT_LEN +: BIT_LEN];
  end

  // Rotate requests so bit 0 is the requester at ptr, then take the first set bit.
  assign req_rot = NUM_REQ'({bus.req, bus.req} >> ptr_q);

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        pick  = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    sum_d   = sum_q;
    err_d   = err_q;
    xfer    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = NUM_REQ'(1) << pick;
          gidx_d  = pick;
          cnt_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (bus.req[gidx_q] && !bus.acc_full) begin
          xfer  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(JOB_LEN - 1)) begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the last watchdog cycle still counts as success.
        if (bus.acc_ready) begin
          sum_d   = bus.acc_sum;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          sum_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          grant_d = '0;
          ptr_d   = (gidx_q == ID_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.grant      = grant_q;
  assign bus.req_pop    = xfer ? grant_q : '0;
  assign bus.acc_wr     = xfer;
  assign bus.acc_data   = xfer ? words[gidx_q] : '0;
  assign bus.acc_start  = (state_q == S_START);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_id    = gidx_q;
  assign bus.resp_sum   = sum_q;
  assign bus.resp_err   = err_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_matrix_job_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_matrix_job_arbiter : job table plus reset and contention sequences
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_matrix_job_arbiter;

  localparam int BIT_LEN = 16;
  localparam int NUM_REQ = 2;
  localparam int JOB_LEN = 18;
  localparam int TIMEOUT = 8;
  localparam int ID_W    = 1;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  matrix_job_arbiter_if #(.BIT_LEN(BIT_LEN), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  matrix_job_arbiter #(
    .BIT_LEN(BIT_LEN), .NUM_REQ(NUM_REQ), .JOB_LEN(JOB_LEN),
    .TIMEOUT(TIMEOUT), .ID_W(ID_W)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  mask;
    int          dly;       // acc_ready this many cycles after START; 0 = never
    logic [31:0] sum;
    int          full_from;
    int          full_to;
    int          drop_n;
    int          hold;      // resp_ready held low this many RESP cycles
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] sum;
    logic        err;
  } resp_t;

  vec_t              vecs[7];
  logic [BIT_LEN-1:0] q_word[$];
  resp_t             q_resp[$];

  int n_cmp = 0;
  int n_bad = 0;

  int jobs_left[NUM_REQ];
  int wcnt[NUM_REQ];
  int cyc, scyc, grant_cyc, start_cyc, valid_cyc, hs_cyc, hs_count;
  int exp_ptr, exp_cur, exp_stream;
  int full_from, full_to, drop_n, resp_hold;
  int acc_dly, acc_t;
  logic [31:0] acc_sum_v;
  bit acc_armed, started, valid_seen, rv_prev, b2b_pending;
  logic [NUM_REQ-1:0] prev_grant;
  int glog[16];
  int glog_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    int    e;
    bit    err;
    resp_t rs;
    int    lat;
    logic [BIT_LEN-1:0] w;
    if (bus.grant != '0 && prev_grant == '0) begin
      e = -1;
      for (int k = 0; k < NUM_REQ; k++)
        if (e < 0 && jobs_left[(exp_ptr + k) % NUM_REQ] > 0) e = (exp_ptr + k) % NUM_REQ;
      if (e < 0) begin
        chk("grant_spurious", 64'(bus.grant), 64'd0);
      end else begin
        chk("grant_order", 64'(bus.grant), 64'(1) << e);
        if (b2b_pending) chk("idle_gap", 64'(cyc - hs_cyc), 64'd2);
        exp_cur   = e;
        started   = 1'b0;
        grant_cyc = cyc;
        if (glog_n < 16) begin
          glog[glog_n] = $clog2(bus.grant);
          glog_n++;
        end
        for (int k = 0; k < JOB_LEN; k++) q_word.push_back(BIT_LEN'(e * 256 + k + 1));
        err    = !(acc_dly > 0 && acc_dly <= TIMEOUT);
        rs.id  = e;
        rs.sum = err ? 32'd0 : acc_sum_v;
        rs.err = err;
        q_resp.push_back(rs);
      end
      b2b_pending = 1'b0;
    end

    chk("grant_onehot", 64'($countones(bus.grant) <= 1), 64'd1);
    if (bus.busy) chk("grant_held", 64'(bus.grant), 64'(1) << exp_cur);
    else          chk("idle_no_grant", 64'(bus.grant), 64'd0);

    if (bus.acc_wr) begin
      chk("wr_no_full", 64'(bus.acc_full), 64'd0);
      chk("req_pop", 64'(bus.req_pop), 64'(1) << exp_cur);
      chk("word_pending", 64'(q_word.size() > 0), 64'd1);
      if (q_word.size() > 0) begin
        w = q_word.pop_front();
        chk("acc_data", 64'(bus.acc_data), 64'(w));
      end
    end else begin
      chk("pop_without_wr", 64'(bus.req_pop), 64'd0);
    end

    for (int r = 0; r < NUM_REQ; r++) begin
      if (bus.req_pop[r]) begin
        wcnt[r]++;
        if (wcnt[r] == JOB_LEN) begin
          wcnt[r] = 0;
          jobs_left[r]--;
        end
      end
    end

    if (bus.acc_start) begin
      chk("start_once", 64'(started), 64'd0);
      chk("start_latency", 64'(cyc - grant_cyc), 64'(exp_stream));
      chk("words_left", 64'(q_word.size()), 64'd0);
      started   = 1'b1;
      start_cyc = cyc;
      acc_armed = 1'b1;
      acc_t     = 0;
    end
    if (bus.acc_ready) acc_armed = 1'b0;

    if (bus.resp_valid) begin
      if (!rv_prev) begin
        lat = (acc_dly > 0 && acc_dly <= TIMEOUT) ? acc_dly + 1 : TIMEOUT + 1;
        chk("resp_latency", 64'(cyc - start_cyc), 64'(lat));
      end
      chk("resp_pending", 64'(q_resp.size() > 0), 64'd1);
      if (q_resp.size() > 0) begin
        chk("resp_id", 64'(bus.resp_id), 64'(q_resp[0].id));
        chk("resp_sum", 64'(bus.resp_sum), 64'(q_resp[0].sum));
        chk("resp_err", 64'(bus.resp_err), 64'(q_resp[0].err));
        if (bus.resp_ready) begin
          void'(q_resp.pop_front());
          exp_ptr     = (exp_cur + 1) % NUM_REQ;
          hs_cyc      = cyc;
          hs_count++;
          valid_seen  = 1'b0;
          b2b_pending = 1'b0;
          for (int r = 0; r < NUM_REQ; r++) if (jobs_left[r] > 0) b2b_pending = 1'b1;
        end
      end
    end
    rv_prev    = bus.resp_valid;
    prev_grant = bus.grant;
  endtask

  // Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
  task automatic cycle();
    bit full_now, drop_now;
    @(posedge Clk);
    #1;
    cyc++;
    if (bus.grant != '0 && !started) scyc++;
    else if (bus.grant == '0)        scyc = 0;
    full_now = (full_to > 0) && (scyc >= full_from) && (scyc <= full_to);
    drop_now = (drop_n > 0) && (scyc > full_to) && (scyc <= full_to + drop_n);
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.req[r] = (jobs_left[r] > 0) && !(drop_now && bus.grant[r]);
      bus.req_data[r*BIT_LEN +: BIT_LEN] = BIT_LEN'(r * 256 + wcnt[r] + 1);
    end
    bus.acc_full = full_now;
    if (acc_armed) acc_t++;
    bus.acc_ready = acc_armed && (acc_dly > 0) && (acc_t == acc_dly);
    bus.acc_sum   = acc_sum_v;
    if (bus.resp_valid && !valid_seen) begin
      valid_seen = 1'b1;
      valid_cyc  = cyc;
    end
    bus.resp_ready = bus.resp_valid ? ((cyc - valid_cyc) >= resp_hold)
                                    : 1'($urandom_range(0, 1));
    @(negedge Clk);
    monitor();
  endtask

  task automatic run_job(input vec_t v);
    int target;
    int n;
    acc_dly    = v.dly;
    acc_sum_v  = v.sum;
    full_from  = v.full_from;
    full_to    = v.full_to;
    drop_n     = v.drop_n;
    resp_hold  = v.hold;
    exp_stream = JOB_LEN + ((v.full_to > 0) ? (v.full_to - v.full_from + 1) + v.drop_n : 0);
    target     = hs_count + $countones(v.mask);
    for (int r = 0; r < NUM_REQ; r++) if (v.mask[r]) jobs_left[r] = 1;
    n = 0;
    while (hs_count < target && n < 400) begin
      cycle();
      n++;
    end
    chk("job_done", 64'(hs_count), 64'(target));
    cycle();
    chk("post_idle", 64'({bus.busy, bus.grant}), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.grant, bus.req_pop, bus.acc_wr, bus.acc_data, bus.acc_start,
                bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_err, bus.busy});
  endfunction

  initial begin
    int n;
    bus.req = '0; bus.req_data = '0; bus.acc_full = 1'b0; bus.acc_ready = 1'b0;
    bus.acc_sum = '0; bus.resp_ready = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin jobs_left[r] = 0; wcnt[r] = 0; end
    cyc = 0; scyc = 0; grant_cyc = 0; start_cyc = 0; valid_cyc = 0; hs_cyc = 0; hs_count = 0;
    exp_ptr = 0; exp_cur = 0; exp_stream = JOB_LEN;
    full_from = 0; full_to = 0; drop_n = 0; resp_hold = 0;
    acc_dly = 0; acc_t = 0; acc_sum_v = '0;
    acc_armed = 0; started = 0; valid_seen = 0; rv_prev = 0; b2b_pending = 0;
    prev_grant = '0; glog_n = 0;

    vecs[0] = '{2'b01, 5, 32'h0000_1234, 0, 0, 0, 0};   // single job
    vecs[1] = '{2'b10, 1, 32'hDEAD_BEEF, 3, 7, 2, 0};   // backpressure + req drop
    vecs[2] = '{2'b01, 0, 32'h5555_5555, 0, 0, 0, 0};   // watchdog timeout
    vecs[3] = '{2'b11, 3, 32'hCAFE_0001, 0, 0, 0, 10};  // response stall, other waits
    vecs[4] = '{2'b01, 8, 32'h7777_8888, 0, 0, 0, 0};   // ready on the timeout cycle
    vecs[5] = '{2'b10, 9, 32'h1111_2222, 0, 0, 0, 0};   // ready one cycle too late
    vecs[6] = '{2'b01, 2, 32'h0000_00AA, 0, 0, 0, 0};

    repeat (3) cycle();
    chk("reset_values", all_outs(), 64'd0);
    Rst = 1'b0;

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Reset while requester 1 is mid-stream (ptr is 1 at this point).
    acc_dly = 2; acc_sum_v = 32'h0000_0BAD; full_to = 0; drop_n = 0; resp_hold = 0;
    exp_stream = JOB_LEN;
    jobs_left[1] = 1;
    n = 0;
    while (wcnt[1] != 9 && n < 100) begin
      cycle();
      n++;
    end
    chk("rst_reach_word9", 64'(wcnt[1]), 64'd9);
    chk("rst_pre_busy", 64'(bus.busy), 64'd1);
    Rst = 1'b1;
    #1;
    chk("rst_async_outputs", all_outs(), 64'd0);
    for (int r = 0; r < NUM_REQ; r++) begin jobs_left[r] = 0; wcnt[r] = 0; end
    q_word.delete(); q_resp.delete();
    exp_ptr = 0; started = 0; acc_armed = 0; valid_seen = 0; rv_prev = 0;
    b2b_pending = 0; prev_grant = '0;
    repeat (2) cycle();
    Rst = 1'b0;

    // Contention: both requesters hold req for two jobs each.
    acc_dly = 2; acc_sum_v = 32'h00AB_CDEF; glog_n = 0;
    jobs_left[0] = 2; jobs_left[1] = 2;
    n = hs_count;
    for (int k = 0; k < 600 && hs_count < n + 4; k++) cycle();
    chk("contention_done", 64'(hs_count), 64'(n + 4));
    chk("contention_grants", 64'(glog_n), 64'd4);
    for (int k = 0; k < 4; k++) chk("rr_order", 64'(glog[k]), 64'(k % 2));
    cycle();
    chk("final_idle", 64'({bus.busy, bus.grant}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
